// File: rtl/uart_ctrl_pkg.sv
// Shared types and default sizing for the UART transmit-side control blocks.
package uart_ctrl_pkg;

  localparam int unsigned DEF_NREQ     = 4;
  localparam int unsigned DEF_START_TO = 4;
  localparam int unsigned DEF_LOCK_TO  = 255;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    START,
    WAIT_ACK,
    WAIT_DONE
  } arbState_t;

  // Byte held for the serializer together with its end-of-packet flag.
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } txByte_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [IDW-1:0] cand;

  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IDW'((32'(ptr) + i) % NREQ);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one start/busy UART transmitter among
// NREQ byte sources.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned NREQ     = DEF_NREQ,
  parameter int unsigned IDW      = $clog2(NREQ),
  parameter int unsigned START_TO = DEF_START_TO,
  parameter int unsigned LOCK_TO  = DEF_LOCK_TO
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              grant_valid,
  output logic [IDW-1:0]    grant_id,
  output logic              err_nobusy
);

  localparam int unsigned LCW = $clog2(LOCK_TO + 1);
  localparam int unsigned SCW = $clog2(START_TO + 1);

  arbState_t      state;
  logic [IDW-1:0] rrPtr;
  logic [IDW-1:0] pickIdx;
  logic           pickAny;
  logic [IDW-1:0] nextPtr;
  logic [LCW-1:0] lockCnt;
  logic [SCW-1:0] startCnt;
  logic           lastQ;
  logic [7:0]     reqByte [NREQ];
  txByte_t        ownerByte;
  logic           ownerValid;
  logic           accept;
  logic           startExpire;
  logic           byteDone;
  logic           lockExpire;
  logic           releaseNow;

  for (genvar g = 0; g < NREQ; g++) begin : gUnpack
    assign reqByte[g] = req_data[8*g +: 8];
  end

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) uPick (
    .req (req_valid),
    .ptr (rrPtr),
    .idx (pickIdx),
    .any (pickAny)
  );

  assign ownerValid = req_valid[grant_id];
  assign ownerByte  = '{last: req_last[grant_id], data: reqByte[grant_id]};
  assign req_ready  = (state == SEND && !tx_busy) ? (NREQ'(1) << grant_id) : '0;
  assign accept     = (state == SEND) && !tx_busy && ownerValid;
  assign nextPtr    = (32'(grant_id) == NREQ - 1) ? '0 : grant_id + IDW'(1);

  // A byte is finished when busy falls, or when busy never showed up in time.
  assign startExpire = (state == WAIT_ACK) && !tx_busy && (startCnt == SCW'(START_TO - 1));
  assign byteDone    = startExpire || ((state == WAIT_DONE) && !tx_busy);
  assign lockExpire  = (state == SEND) && !tx_busy && !ownerValid
                       && (lockCnt == LCW'(LOCK_TO - 1));
  assign releaseNow  = lockExpire || (byteDone && lastQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rrPtr       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      err_nobusy  <= 1'b0;
      lockCnt     <= '0;
      startCnt    <= '0;
      lastQ       <= 1'b0;
    end else begin
      tx_start   <= 1'b0;
      err_nobusy <= startExpire;
      if (releaseNow) begin
        grant_valid <= 1'b0;
        rrPtr       <= nextPtr;
        lockCnt     <= '0;
        state       <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (pickAny) begin
              grant_id    <= pickIdx;
              grant_valid <= 1'b1;
              lockCnt     <= '0;
              state       <= SEND;
            end
          end
          SEND: begin
            if (accept) begin
              tx_data  <= ownerByte.data;
              lastQ    <= ownerByte.last;
              lockCnt  <= '0;
              tx_start <= 1'b1;
              state    <= START;
            end else if (!ownerValid && !tx_busy) begin
              lockCnt <= lockCnt + LCW'(1);
            end
          end
          START: begin
            // The start cycle itself counts toward the busy timeout.
            startCnt <= SCW'(1);
            state    <= WAIT_ACK;
          end
          WAIT_ACK: begin
            if (tx_busy) begin
              state <= WAIT_DONE;
            end else if (startExpire) begin
              state <= SEND;
            end else begin
              startCnt <= startCnt + SCW'(1);
            end
          end
          WAIT_DONE: begin
            if (byteDone) begin
              state <= SEND;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a byte-source model per requester
// and a start/busy transmitter model.
module tb_uart_tx_arbiter;

  localparam int unsigned NREQ = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic              grant_valid;
  logic [1:0]        grant_id;
  logic              err_nobusy;

  uart_tx_arbiter #(
    .NREQ     (4),
    .IDW      (2),
    .START_TO (4),
    .LOCK_TO  (255)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .err_nobusy  (err_nobusy)
  );

  always #5 clk = ~clk;

  // Transmitter: busy rises the edge after tx_start and stays up 10 cycles.
  logic busyEn;
  int   busyCnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy <= 1'b0;
      busyCnt <= 0;
    end else if (tx_start && busyEn) begin
      tx_busy <= 1'b1;
      busyCnt <= 10;
    end else if (busyCnt == 1) begin
      tx_busy <= 1'b0;
      busyCnt <= 0;
    end else if (busyCnt > 1) begin
      busyCnt <= busyCnt - 1;
    end
  end

  logic [7:0]  srcData [NREQ][4];
  logic        srcLast [NREQ][4];
  int          srcLen  [NREQ];
  int          srcPos  [NREQ];
  logic [11:0] txLog [$];
  int          nChecks = 0;
  int          nFails  = 0;
  int          errCount = 0;
  int          n;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic driveSrc();
    logic [7:0] b [NREQ];
    for (int i = 0; i < NREQ; i++) begin
      if (srcPos[2'(i)] < srcLen[2'(i)]) begin
        req_valid[2'(i)] = 1'b1;
        req_last[2'(i)]  = srcLast[2'(i)][2'(srcPos[2'(i)])];
        b[2'(i)]         = srcData[2'(i)][2'(srcPos[2'(i)])];
      end else begin
        req_valid[2'(i)] = 1'b0;
        req_last[2'(i)]  = 1'b0;
        b[2'(i)]         = 8'h00;
      end
    end
    req_data = {b[3], b[2], b[1], b[0]};
  endtask

  task automatic clearSrc();
    for (int i = 0; i < NREQ; i++) begin
      srcLen[2'(i)] = 0;
      srcPos[2'(i)] = 0;
    end
  endtask

  task automatic addByte(input int r, input logic [7:0] d, input logic l);
    srcData[2'(r)][2'(srcLen[2'(r)])] = d;
    srcLast[2'(r)][2'(srcLen[2'(r)])] = l;
    srcLen[2'(r)]++;
  endtask

  // One clock: transfers seen at this negedge complete at the coming posedge.
  task automatic tick();
    logic [NREQ-1:0] acc;
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (acc[2'(i)]) srcPos[2'(i)]++;
    driveSrc();
    @(negedge clk);
    if (tx_start) txLog.push_back({2'b00, grant_id, tx_data});
    if (err_nobusy) errCount++;
  endtask

  task automatic waitLog(input string tag, input int want, input int budget);
    int k = 0;
    while (txLog.size() < want && k < budget) begin
      tick();
      k++;
    end
    checkEq(tag, 32'(txLog.size()), 32'(want));
  endtask

  task automatic cyclesToRelease(input int budget, output int cyc);
    cyc = 0;
    while (grant_valid && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    busyEn = 1'b1;
    clearSrc();
    driveSrc();
    txLog.delete();
    errCount = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    busyEn = 1'b1;
    clearSrc();
    driveSrc();
    @(negedge clk);
    checkEq("rst req_ready", 32'(req_ready), 32'h0);
    checkEq("rst tx_start", 32'(tx_start), 32'h0);
    checkEq("rst tx_data", 32'(tx_data), 32'h0);
    checkEq("rst grant_valid", 32'(grant_valid), 32'h0);
    checkEq("rst grant_id", 32'(grant_id), 32'h0);
    checkEq("rst err_nobusy", 32'(err_nobusy), 32'h0);
    resetDut();

    // Single requester 1, one byte 0x41 flagged last.
    addByte(1, 8'h41, 1'b1);
    driveSrc();
    tick();
    checkEq("t1 grant_valid", 32'(grant_valid), 32'h1);
    checkEq("t1 grant_id", 32'(grant_id), 32'h1);
    checkEq("t1 req_ready", 32'(req_ready), 32'h2);
    tick();
    checkEq("t1 tx_start", 32'(tx_start), 32'h1);
    checkEq("t1 tx_data", 32'(tx_data), 32'h41);
    checkEq("t1 ready after accept", 32'(req_ready), 32'h0);
    cyclesToRelease(50, n);
    checkEq("t1 release latency", 32'(n), 32'd12);

    // Pointer now at 2: requester 2's packet goes first and is not interleaved.
    addByte(2, 8'h10, 1'b0);
    addByte(2, 8'h11, 1'b0);
    addByte(2, 8'h12, 1'b1);
    addByte(0, 8'h55, 1'b1);
    driveSrc();
    tick();
    checkEq("t3 grant_id", 32'(grant_id), 32'h2);
    waitLog("t3 byte count", 5, 300);
    checkEq("t3 byte0", 32'(txLog[1]), 32'h210);
    checkEq("t3 byte1", 32'(txLog[2]), 32'h211);
    checkEq("t3 byte2", 32'(txLog[3]), 32'h212);
    checkEq("t3 req0 after", 32'(txLog[4]), 32'h055);

    // All four requesters, two single-byte packets each.
    resetDut();
    for (int i = 0; i < NREQ; i++) begin
      addByte(i, 8'hA0 + 8'(i), 1'b1);
      addByte(i, 8'hB0 + 8'(i), 1'b1);
    end
    driveSrc();
    waitLog("t2 byte count", 8, 600);
    for (int k = 0; k < 8; k++) begin
      logic [11:0] exp;
      exp = {2'b00, 2'(k % 4), (k < 4) ? 8'hA0 + 8'(k) : 8'hB0 + 8'(k - 4)};
      checkEq($sformatf("t2 order %0d", k), 32'(txLog[k]), 32'(exp));
    end

    // Owner goes quiet mid-packet; lock expires after 255 idle cycles.
    resetDut();
    addByte(1, 8'h21, 1'b0);
    addByte(3, 8'h33, 1'b1);
    driveSrc();
    waitLog("t4 first byte", 1, 50);
    cyclesToRelease(400, n);
    checkEq("t4 lock release latency", 32'(n), 32'd267);
    waitLog("t4 byte count", 2, 100);
    checkEq("t4 byte0", 32'(txLog[0]), 32'h121);
    checkEq("t4 next owner", 32'(txLog[1]), 32'h333);

    // Transmitter never goes busy.
    resetDut();
    busyEn = 1'b0;
    addByte(0, 8'h61, 1'b0);
    addByte(0, 8'h62, 1'b1);
    driveSrc();
    waitLog("t5 first byte", 1, 20);
    n = 0;
    while (!err_nobusy && n < 20) begin
      tick();
      n++;
    end
    checkEq("t5 err latency", 32'(n), 32'd4);
    tick();
    checkEq("t5 err pulse width", 32'(err_nobusy), 32'h0);
    waitLog("t5 second byte", 2, 20);
    checkEq("t5 byte1", 32'(txLog[1]), 32'h062);
    cyclesToRelease(50, n);
    checkEq("t5 release latency", 32'(n), 32'd4);
    checkEq("t5 err count", 32'(errCount), 32'd2);

    // Asynchronous reset while the transmitter is busy.
    resetDut();
    addByte(3, 8'h77, 1'b1);
    driveSrc();
    waitLog("t6 first byte", 1, 20);
    repeat (4) tick();
    checkEq("t6 busy before reset", 32'(tx_busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkEq("t6 grant_valid", 32'(grant_valid), 32'h0);
    checkEq("t6 grant_id", 32'(grant_id), 32'h0);
    checkEq("t6 tx_data", 32'(tx_data), 32'h0);
    checkEq("t6 req_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    clearSrc();
    txLog.delete();
    addByte(0, 8'h80, 1'b1);
    addByte(2, 8'h82, 1'b1);
    driveSrc();
    waitLog("t6 byte count", 2, 100);
    checkEq("t6 restart req0", 32'(txLog[0]), 32'h080);
    checkEq("t6 then req2", 32'(txLog[1]), 32'h282);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
